// File: rtl/ddr_word_packer.sv
// Pairs DDR rise/fall captures into {neg,pos} words, aligns to a sync byte and
// buffers them in a show-ahead FIFO. Aligner compiled in with DDR_PACKER_SYNC_EN.
module ddr_word_packer #(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] SYNC_PAT = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       pos_data,
  input  logic [DATA_W-1:0]       neg_data,
  input  logic                    resync,
  input  logic                    clear_ovf,
  output logic                    out_valid,
  output logic [2*DATA_W-1:0]     out_data,
  input  logic                    out_ready,
  output logic                    locked,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]    FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]    ZERO_LVL = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0]    ONE_LVL  = LVL_W'(1'b1);
  localparam logic [PTR_W-1:0]    ZERO_PTR = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]    ONE_PTR  = PTR_W'(1'b1);
  localparam logic [2*DATA_W-1:0] ZERO_WRD = {(2*DATA_W){1'b0}};

  logic [2*DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_overflow;

  logic w_accept;
  logic w_cand;
  logic w_pop;
  logic w_push;
  logic w_drop;

`ifdef DDR_PACKER_SYNC_EN
  typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;
  state_t r_state;

  // Aligner: resync beats a sync match; the sync word itself is never pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (resync)                              r_state <= ST_HUNT;
          else if (in_valid && pos_data == SYNC_PAT) r_state <= ST_LOCKED;
          else                                     r_state <= ST_HUNT;
        end
        ST_LOCKED: begin
          if (resync) r_state <= ST_HUNT;
          else        r_state <= ST_LOCKED;
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  assign w_accept = (r_state == ST_LOCKED) && !resync;
  assign locked   = (r_state == ST_LOCKED);
`else
  localparam logic [DATA_W-1:0] UNUSED_SYNC_PAT = SYNC_PAT;
  logic w_unused_resync;
  assign w_unused_resync = resync;
  assign w_accept        = 1'b1;
  assign locked          = 1'b1;
`endif

  assign w_cand = in_valid && w_accept;

  // Push/pop/drop decode; a full FIFO still accepts when it pops the same cycle.
  always_comb begin
    w_pop  = (r_level != ZERO_LVL) && out_ready;
    w_push = 1'b0;
    w_drop = 1'b0;
    if (w_cand) begin
      if ((r_level != FULL_LVL) || w_pop) begin
        w_push = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end else begin
      w_push = 1'b0;
      w_drop = 1'b0;
    end
  end

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= ZERO_WRD;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {neg_data, pos_data};
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers, occupancy and the sticky overflow flag (a drop wins over clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= ZERO_PTR;
      r_rd_ptr   <= ZERO_PTR;
      r_level    <= ZERO_LVL;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ONE_PTR;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + ONE_PTR;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE_LVL;
        2'b01:   r_level <= r_level - ONE_LVL;
        default: r_level <= r_level;
      endcase
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
      else                r_overflow <= r_overflow;
    end
  end

  assign out_valid = (r_level != ZERO_LVL);
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ddr_word_packer.sv
// Directed self-checking bench for ddr_word_packer; follows DDR_PACKER_SYNC_EN.
module tb_ddr_word_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  pos_data;
  logic [7:0]  neg_data;
  logic        resync;
  logic        clear_ovf;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        locked;
  logic        overflow;
  logic [2:0]  level;

  int checks   = 0;
  int failures = 0;

`ifdef DDR_PACKER_SYNC_EN
  localparam logic EXP_LOCK_RST = 1'b0;
`else
  localparam logic EXP_LOCK_RST = 1'b1;
`endif

  ddr_word_packer #(.DATA_W(8), .DEPTH(4), .SYNC_PAT(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .pos_data(pos_data),
    .neg_data(neg_data), .resync(resync), .clear_ovf(clear_ovf),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .locked(locked), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    resync    = 1'b0;
    clear_ovf = 1'b0;
  endtask

  task automatic put(input logic iv, input logic [7:0] p, input logic [7:0] n, input logic rdy);
    in_valid  = iv;
    pos_data  = p;
    neg_data  = n;
    out_ready = rdy;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; pos_data = 8'h00; neg_data = 8'h00;
    resync = 1'b0; clear_ovf = 1'b0; out_ready = 1'b0;
    #12;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", out_data); end
    checks++; if (locked !== EXP_LOCK_RST) begin failures++; $display("FAIL reset_locked got=%b exp=%b", locked, EXP_LOCK_RST); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_sync();
`ifdef DDR_PACKER_SYNC_EN
    put(1'b1, 8'h11, 8'h22, 1'b0);
    put(1'b1, 8'h22, 8'h11, 1'b0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL hunt_locked got=%b exp=0", locked); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hunt_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL hunt_level got=%0d exp=0", level); end
`else
    put(1'b1, 8'h11, 8'h22, 1'b0);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL nosync_level got=%0d exp=1", level); end
    checks++; if (out_data !== 16'h2211) begin failures++; $display("FAIL nosync_data got=%h exp=2211", out_data); end
    put(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL nosync_drain got=%b exp=0", out_valid); end
`endif
  endtask

  task automatic test_sync();
    put(1'b1, 8'hA5, 8'h00, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL sync_locked got=%b exp=1", locked); end
`ifdef DDR_PACKER_SYNC_EN
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL sync_word_dropped got=%0d exp=0", level); end
    put(1'b1, 8'h34, 8'h12, 1'b0);
    checks++; if (out_data !== 16'h1234) begin failures++; $display("FAIL sync_first_data got=%h exp=1234", out_data); end
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL sync_first_level got=%0d exp=1", level); end
    put(1'b0, 8'h00, 8'h00, 1'b1);
`else
    checks++; if (out_data !== 16'h00A5) begin failures++; $display("FAIL sync_word_kept got=%h exp=00a5", out_data); end
    put(1'b1, 8'h34, 8'h12, 1'b0);
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL sync_level2 got=%0d exp=2", level); end
    put(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (out_data !== 16'h1234) begin failures++; $display("FAIL sync_second_data got=%h exp=1234", out_data); end
    put(1'b0, 8'h00, 8'h00, 1'b1);
`endif
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL sync_drain got=%0d exp=0", level); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 8'h60 + 8'(i), 8'h70 + 8'(i), 1'b1);
      checks++; if (level !== 3'd1) begin failures++; $display("FAIL b2b_level[%0d] got=%0d exp=1", i, level); end
      checks++; if (out_data !== {8'h70 + 8'(i), 8'h60 + 8'(i)}) begin failures++; $display("FAIL b2b_data[%0d] got=%h", i, out_data); end
    end
    put(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 6; i++) begin
      put(1'b1, 8'h40 + 8'(i), 8'hB0 + 8'(i), 1'b0);
      if (i == 4) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_ovf_at_full got=%b exp=0", overflow); end
      end
    end
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL bp_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL bp_ovf got=%b exp=1", overflow); end
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL bp_locked got=%b exp=1", locked); end
    for (int j = 1; j <= 4; j++) begin
      checks++; if (out_data !== {8'hB0 + 8'(j), 8'h40 + 8'(j)}) begin failures++; $display("FAIL bp_order[%0d] got=%h", j, out_data); end
      put(1'b0, 8'h00, 8'h00, 1'b1);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
    clear_ovf = 1'b1;
    put(1'b0, 8'h00, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL bp_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) put(1'b1, 8'hC0 + 8'(i), 8'hD0 + 8'(i), 1'b0);
    put(1'b1, 8'hC4, 8'hD4, 1'b1);
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL fpp_level got=%0d exp=4", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    for (int j = 1; j <= 4; j++) begin
      checks++; if (out_data !== {8'hD0 + 8'(j), 8'hC0 + 8'(j)}) begin failures++; $display("FAIL fpp_order[%0d] got=%h", j, out_data); end
      put(1'b0, 8'h00, 8'h00, 1'b1);
    end
    for (int i = 0; i < 4; i++) put(1'b1, 8'h01, 8'h02, 1'b0);
    clear_ovf = 1'b1;
    put(1'b1, 8'h03, 8'h04, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL set_beats_clear got=%b exp=1", overflow); end
    clear_ovf = 1'b1;
    put(1'b0, 8'h00, 8'h00, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_only got=%b exp=0", overflow); end
    for (int i = 0; i < 4; i++) put(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL fpp_drain got=%0d exp=0", level); end
  endtask

  task automatic test_resync();
    put(1'b1, 8'hE0, 8'hF0, 1'b0);
    put(1'b1, 8'hE1, 8'hF1, 1'b0);
    resync = 1'b1;
    put(1'b1, 8'hEE, 8'hFE, 1'b0);
`ifdef DDR_PACKER_SYNC_EN
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rs_locked got=%b exp=0", locked); end
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL rs_level got=%0d exp=2", level); end
    put(1'b1, 8'h55, 8'h66, 1'b0);
    put(1'b1, 8'h56, 8'h67, 1'b0);
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL rs_hunt_discard got=%0d exp=2", level); end
`else
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL rs_ignored_locked got=%b exp=1", locked); end
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL rs_ignored_level got=%0d exp=3", level); end
`endif
    checks++; if (out_data !== 16'hF0E0) begin failures++; $display("FAIL rs_drain0 got=%h exp=f0e0", out_data); end
    put(1'b0, 8'h00, 8'h00, 1'b1);
    checks++; if (out_data !== 16'hF1E1) begin failures++; $display("FAIL rs_drain1 got=%h exp=f1e1", out_data); end
    put(1'b0, 8'h00, 8'h00, 1'b1);
`ifndef DDR_PACKER_SYNC_EN
    checks++; if (out_data !== 16'hFEEE) begin failures++; $display("FAIL rs_drain2 got=%h exp=feee", out_data); end
    put(1'b0, 8'h00, 8'h00, 1'b1);
`endif
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rs_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
`ifdef DDR_PACKER_SYNC_EN
    put(1'b1, 8'hA5, 8'h00, 1'b0);
`endif
    for (int i = 0; i < 5; i++) put(1'b1, 8'h90 + 8'(i), 8'h80, 1'b0);
    put(1'b0, 8'h00, 8'h00, 1'b1);
    out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL ar_pre_level got=%0d exp=3", level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ar_pre_ovf got=%b exp=1", overflow); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL ar_level got=%0d exp=0", level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ar_ovf got=%b exp=0", overflow); end
    checks++; if (locked !== EXP_LOCK_RST) begin failures++; $display("FAIL ar_locked got=%b exp=%b", locked, EXP_LOCK_RST); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_no_sync();
    test_sync();
    test_back_to_back();
    test_backpressure();
    test_full_pop_push();
    test_resync();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_word_packer.md
# ddr_word_packer

Downstream consumer of the DDR capture stage. Pairs the rising-edge and falling-edge capture registers into one word per `clk` cycle and aligns the stream to a sync byte. Buffers the words in a small FIFO and presents them on a valid/ready output port. Sits between the DDR input capture and the first single-data-rate processing stage.

## Interface
- `DATA_W`, 8: width of each half-cycle sample.
- `DEPTH`, 4: FIFO depth in words. Must be a power of 2, ≥2.
- `SYNC_PAT`, 8'hA5: alignment pattern compared against `pos_data`. Width `DATA_W`.

- `clk`  in  1: clock. Same clock that drives the DDR capture stage.
- `rst_n`  in  1: reset. Asynchronous, active-low.
- `in_valid`  in  1: capture stage holds a valid pos/neg pair this cycle.
- `pos_data`  in  DATA_W: rising-edge capture (earlier sample in time).
- `neg_data`  in  DATA_W: falling-edge capture (later sample in time).
- `resync`  in  1: one-cycle pulse. Forces the aligner back to HUNT.
- `clear_ovf`  in  1: clears the sticky `overflow` flag.
- `out_valid`  out  1: FIFO head is valid.
- `out_data`  out  2*DATA_W: packed word, `{neg_data, pos_data}`.
- `out_ready`  in  1: consumer accepts the head word.
- `locked`  out  1: aligner is in the LOCKED state.
- `overflow`  out  1: sticky flag. Set when a word is dropped because the FIFO is full.
- `level`  out  $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.

## Operation
- Pairing: at posedge k, `pos_data` holds the sample from posedge k-1 and `neg_data` holds the sample from the following negedge. The candidate word is `{neg_data, pos_data}`, sampled only when `in_valid`=1.
- Aligner FSM, two states:
  - HUNT: words are discarded. If `in_valid` and `pos_data==SYNC_PAT`, go to LOCKED. The sync word itself is discarded.
  - LOCKED: every `in_valid` word is a push candidate.
  - `resync`=1 goes to HUNT from either state and takes priority over a sync match. A push candidate in the same cycle as `resync` is discarded.
- FIFO: show-ahead, DEPTH entries, with read pointer, write pointer and `level` counter. Pointers wrap modulo DEPTH.
  - Pop occurs when `out_valid && out_ready`.
  - Push occurs on a candidate when `level<DEPTH`, or when `level==DEPTH` and a pop happens in the same cycle. In that case `level` stays unchanged and no drop occurs.
  - A candidate with `level==DEPTH` and no pop is dropped. `overflow` is set and the FSM stays LOCKED.
- `out_valid = (level!=0)`. `out_data` = entry at the read pointer, and is held stable while `out_valid && !out_ready`.
- Flag priority: `clear_ovf` and a drop in the same cycle leave `overflow`=1 (set wins).
- `resync` does not flush the FIFO. Words already stored drain normally.
- Reset values: FSM=HUNT, pointers=0, `level`=0, `out_valid`=0, `out_data`=0, `locked`=0, `overflow`=0. Reset mid-operation discards all FIFO contents immediately and asynchronously.

## Timing
- Push to `out_valid`: a word pushed at posedge k is visible after posedge k (1 cycle). There is no combinational bypass from input to output.
- Sync match at posedge k: `locked`=1 after posedge k. The first packed word is the next `in_valid` pair at posedge ≥ k+1.
- `locked` falls one cycle after `resync`.
- Full throughput: one word per cycle in and out with `out_ready` held high.
- `out_ready` to `level`: updated at the same posedge. There is no combinational path from `out_ready` to `out_valid`.

## Configuration
- `DDR_PACKER_SYNC_EN`:
  - Defined: the HUNT/LOCKED aligner is compiled in as described.
  - Undefined: the FSM is removed. `locked` is tied to 1, `resync` is ignored, and every `in_valid` pair is a push candidate from the first cycle after reset. FIFO and overflow behaviour are unchanged.

## Test plan
- Reset, then `pos_data`=8'h11/8'h22 with `in_valid` and no sync byte (SYNC_EN defined) → `locked`=0, `out_valid` stays 0, `level`=0.
- Sync: pair (pos=8'hA5, neg=8'h00), then (pos=8'h34, neg=8'h12) → `locked`=1 one cycle after the first pair. One cycle after the second pair, `out_data`=16'h1234 and `level`=1.
- Backpressure with `out_ready`=0, DEPTH=4, LOCKED, six consecutive words → `level`=4, `overflow`=1, and words 5–6 are dropped. After `out_ready`=1, exactly words 1–4 come out in order.
- Full with `out_ready`=1 and a push in the same cycle → `level` stays 4, `overflow` stays 0, the new word appears after the existing 4.
- `resync` pulse while LOCKED with 2 words buffered → `locked`=0 next cycle, both buffered words still drain, and subsequent non-sync pairs are discarded.
- Assert `rst_n`=0 mid-stream with `level`=3 → `out_valid`=0, `level`=0, `overflow`=0, `locked`=0 immediately, without waiting for a clock edge.
